// File: rtl/pong_pkg.sv
// pong_pkg: shared state, winner and serve encodings for the match-level logic
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    // Scores are single BCD digits, so the limit (<= 9) also caps the digit
    function automatic logic [3:0] bcd_inc_sat(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// match_ctrl_if: game-core inputs and scoreboard/serve outputs of the match sequencer
interface match_ctrl_if;
    logic       start;
    logic       out_left;
    logic       out_right;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       serve_hold;
    logic       serve_dir;
    logic       game_over;
    logic [1:0] winner;
    logic       blink;

    modport master (
        output start, out_left, out_right,
        input  score_p1, score_p2, serve_hold, serve_dir, game_over, winner, blink
    );

    modport slave (
        input  start, out_left, out_right,
        output score_p1, score_p2, serve_hold, serve_dir, game_over, winner, blink
    );
endinterface

// File: rtl/match_ctrl_edge_rise.sv
// edge_rise: registered single-bit rising-edge detector with sync reset
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= d;
            rise <= d & ~prev;
        end
    end
endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: counts points, pauses between rallies, detects the winner and latches game-over
module match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 1500,
    parameter int DELAYWIDTH  = 11,
    parameter int BLINK_HALF  = 375
) (
    input logic         clk,
    input logic         reset,
    match_ctrl_if.slave bus
);
    localparam logic [3:0]            WIN        = 4'(WIN_SCORE);
    localparam logic [DELAYWIDTH-1:0] PAUSE_LAST = DELAYWIDTH'(SERVE_DELAY - 1);
    localparam logic [DELAYWIDTH-1:0] BLINK_LAST = DELAYWIDTH'(BLINK_HALF - 1);

    state_t                state, state_d;
    logic [DELAYWIDTH-1:0] cnt, cnt_d;
    logic [3:0]            p1, p1_d, p2, p2_d, inc1, inc2;
    logic                  dir, dir_d, hold, over, over_d, blink, blink_d;
    logic [1:0]            win, win_d;
    logic                  rise_l, rise_r;

    edge_rise u_rise_l (.clk(clk), .reset(reset), .d(bus.out_left),  .rise(rise_l));
    edge_rise u_rise_r (.clk(clk), .reset(reset), .d(bus.out_right), .rise(rise_r));

    assign inc1 = bcd_inc_sat(p1, WIN);
    assign inc2 = bcd_inc_sat(p2, WIN);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        p1_d    = p1;
        p2_d    = p2;
        dir_d   = dir;
        over_d  = over;
        win_d   = win;
        blink_d = blink;
        case (state)
            IDLE: if (bus.start) begin
                state_d = PLAY;
                cnt_d   = '0;
                p1_d    = 4'd0;
                p2_d    = 4'd0;
                win_d   = WIN_NONE;
                over_d  = 1'b0;
            end
            PLAY: if (rise_l | rise_r) begin
                state_d = POINT;
                cnt_d   = '0;
                // Simultaneous exits cancel out: pause without scoring
                if (rise_l & ~rise_r) begin
                    p2_d  = inc2;
                    dir_d = SERVE_LEFT;
                    if (inc2 == WIN) begin
                        state_d = OVER;
                        win_d   = WIN_P2;
                        over_d  = 1'b1;
                        blink_d = 1'b1;
                    end
                end else if (rise_r & ~rise_l) begin
                    p1_d  = inc1;
                    dir_d = SERVE_RIGHT;
                    if (inc1 == WIN) begin
                        state_d = OVER;
                        win_d   = WIN_P1;
                        over_d  = 1'b1;
                        blink_d = 1'b1;
                    end
                end
            end
            POINT: begin
                cnt_d   = (cnt == PAUSE_LAST) ? '0 : cnt + 1'b1;
                state_d = (cnt == PAUSE_LAST) ? PLAY : POINT;
            end
            OVER: if (bus.start) begin
                state_d = IDLE;
                cnt_d   = '0;
                over_d  = 1'b0;
                win_d   = WIN_NONE;
                blink_d = 1'b0;
            end else begin
                cnt_d   = (cnt == BLINK_LAST) ? '0 : cnt + 1'b1;
                blink_d = (cnt == BLINK_LAST) ? ~blink : blink;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            p1    <= 4'd0;
            p2    <= 4'd0;
            dir   <= SERVE_LEFT;
            hold  <= 1'b1;
            over  <= 1'b0;
            win   <= WIN_NONE;
            blink <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            p1    <= p1_d;
            p2    <= p2_d;
            dir   <= dir_d;
            hold  <= (state_d != PLAY);
            over  <= over_d;
            win   <= win_d;
            blink <= blink_d;
        end
    end

    assign bus.score_p1   = p1;
    assign bus.score_p2   = p2;
    assign bus.serve_dir  = dir;
    assign bus.serve_hold = hold;
    assign bus.game_over  = over;
    assign bus.winner     = win;
    assign bus.blink      = blink;
endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
- Match-level sequencer, directly downstream of the game core's out_left/out_right outputs.
- Drives the scoreboard's score_p1/score_p2 inputs and gates ball serving.
- Counts points, holds a timed pause between rallies, detects the match winner, and latches game-over until a new start.
- Runs in the game_clk domain (1500 Hz nominal), connected to its clk port.

Parameters:
- WIN_SCORE, 9: points needed to win; legal range 1..9, scores are single BCD digits.
- SERVE_DELAY, 1500: clk ticks of pause after a point before re-serve.
- DELAYWIDTH, 11: width of the pause/blink counter; must hold SERVE_DELAY-1.
- BLINK_HALF, 375: clk ticks per half-period of the game-over blink.

Ports:
- clk  in  1  game tick clock
- reset  in  1  synchronous, active-high
- start  in  1  debounced start button, level
- out_left  in  1  ball passed left edge, level from game core
- out_right  in  1  ball passed right edge, level from game core
- score_p1  out  4  BCD score of player 1 (left)
- score_p2  out  4  BCD score of player 2 (right)
- serve_hold  out  1  1 = ball frozen at centre, game core must not advance
- serve_dir  out  1  0 = serve toward left, 1 = toward right
- game_over  out  1  match finished
- winner  out  2  00 none, 01 player 1, 10 player 2
- blink  out  1  game-over display blink, 0 when not game_over

Behaviour:
- Reset (sync, clk edge with reset=1):
  - state=IDLE.
  - score_p1=0, score_p2=0, serve_hold=1, serve_dir=0, game_over=0, winner=00, blink=0.
  - Counter=0; edge-detect history registers cleared to 0.
  - Reset mid-operation in any state returns to this state on the same edge.
- Edge detection:
  - A point event is the rising edge of out_left or out_right, based on a one-cycle registered history.
  - Levels held high produce only one event.
- Point attribution:
  - Rising out_left: player 2 scores, serve_dir<=0 (serve toward the loser).
  - Rising out_right: player 1 scores, serve_dir<=1.
  - Both rising in the same cycle: no score change, serve_dir unchanged; still enter POINT.
- States (outputs are registered, so a transition takes effect 1 clk after its cause):
  - IDLE: serve_hold=1.
    - start=1: scores<=0, winner<=00, game_over<=0 → PLAY.
  - PLAY: serve_hold=0.
    - Point event: increment the scorer's score, counter<=0, then:
      - new score == WIN_SCORE → OVER.
      - otherwise → POINT.
    - start is ignored in PLAY.
  - POINT: serve_hold=1; counter increments each clk.
    - counter == SERVE_DELAY-1 → PLAY, counter<=0.
    - Point events are ignored.
  - OVER: serve_hold=1, game_over=1, winner set to the scorer.
    - Counter runs 0..BLINK_HALF-1 and wraps; blink toggles on each wrap, starting high on entry.
    - start=1 → IDLE, which clears blink/game_over; the next start begins a new match.
    - Point events are ignored.
- Arithmetic:
  - Score increment is a saturating BCD add at WIN_SCORE; a digit never exceeds 9.
  - The counter wraps in DELAYWIDTH bits.
- Latency:
  - Point event to score update: 2 clk after the input rises (1 edge-detect + 1 register).
  - serve_hold rises in the same cycle the score updates.

Decomposition:
- Shared package pong_pkg:
  - State encoding: IDLE=2'd0, PLAY=2'd1, POINT=2'd2, OVER=2'd3.
  - Winner codes: WIN_NONE, WIN_P1, WIN_P2.
  - SERVE_LEFT/SERVE_RIGHT constants.
- One natural sub-module, edge_rise: single-bit registered rising-edge detector with sync reset, instanced twice.
- The score registers and FSM stay in match_ctrl.

Test Plan:
- Reset, then start pulse:
  - 1 clk after start: serve_hold=0, scores 0/0, winner=00.
  - After start is released: state stays PLAY.
- In PLAY, out_right high for 5 clk:
  - score_p1=1 exactly 2 clk after the rise, only once.
  - serve_dir=1, serve_hold=1 for SERVE_DELAY (use 8 in bench), then 0.
- Both out_left and out_right rise in the same cycle:
  - Scores unchanged, serve_dir unchanged, serve_hold=1 for SERVE_DELAY ticks.
- With WIN_SCORE=3, player 2 scores three points:
  - score_p2=3, game_over=1, winner=10, serve_hold=1.
  - blink toggles every BLINK_HALF ticks.
  - Further out_left/out_right edges are ignored.
- In OVER, start pulse:
  - Next clk: game_over=0, blink=0, winner=00.
  - Second start pulse: scores 0/0, PLAY.
- Assert reset mid-POINT (counter=4):
  - Next clk: all outputs at reset values, state IDLE.
  - The out_left level held high through reset release produces no point.
